// File: rtl/upsize_pair_arbiter.sv
// ---------------------------------------------------------------------------
// upsize_pair_arbiter
//
// Round-robin arbiter that shares the W-bit AXI-Stream input of a 2:1 upsizer
// between N requesters. A grant is held for exactly two accepted beats, so
// every 2W upsized word carries data from a single source. The output passes
// through a one-entry register stage, so all out_* signals are flop-driven.
//
// Ports:
//   aclk        clock, rising edge
//   aresetn     asynchronous active-low reset
//   in_tdata    N*W  requester data, source i at [i*W +: W]
//   in_tvalid   N    per-requester valid
//   in_tready   N    per-requester ready (combinational)
//   out_tdata   W    beat to the upsizer
//   out_tvalid  1    output valid
//   out_tready  1    upsizer ready
//   out_tid     IDW  source index of the current output beat
//   out_tlast   1    1 = second beat of a pair
//   busy        1    1 while a pair is open
// ---------------------------------------------------------------------------
module upsize_pair_arbiter #(
  parameter int W   = 40,
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic [N*W-1:0] in_tdata,
  input  logic [N-1:0]   in_tvalid,
  output logic [N-1:0]   in_tready,
  output logic [W-1:0]   out_tdata,
  output logic           out_tvalid,
  input  logic           out_tready,
  output logic [IDW-1:0] out_tid,
  output logic           out_tlast,
  output logic           busy
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SECOND = 1'b1
  } state_t;

  state_t         state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] rr_ptr_d;
  logic [IDW-1:0] grant_q;
  logic [W-1:0]   out_tdata_q;
  logic           out_tvalid_q;
  logic [IDW-1:0] out_tid_q;
  logic           out_tlast_q;

  logic [IDW-1:0] pick;
  logic           pick_vld;
  logic [IDW-1:0] sel;
  logic           sel_vld;
  logic           stage_ok;
  logic           hs;

  // First valid requester searching upward from rr_ptr, wrapping mod N.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = rr_ptr_q;
    pick_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!pick_vld && in_tvalid[idx]) begin
        pick     = IDW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // The output register can take a beat when empty or draining this cycle.
  assign stage_ok = ~out_tvalid_q | out_tready;

  // While a pair is open only the granted source is served, even across gaps.
  assign sel     = (state_q == S_SECOND) ? grant_q : pick;
  assign sel_vld = (state_q == S_SECOND) ? in_tvalid[grant_q] : pick_vld;
  assign hs      = sel_vld & stage_ok;

  always_comb begin
    in_tready = '0;
    if (state_q == S_SECOND) begin
      in_tready[grant_q] = stage_ok;
    end else if (pick_vld) begin
      in_tready[pick] = stage_ok;
    end
  end

  // Next pair starts searching just after the source that completed.
  assign rr_ptr_d = (grant_q == IDW'(N - 1)) ? '0 : grant_q + IDW'(1);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      out_tdata_q  <= '0;
      out_tvalid_q <= 1'b0;
      out_tid_q    <= '0;
      out_tlast_q  <= 1'b0;
    end else begin
      // A load takes priority over a drain in the same cycle.
      if (hs) begin
        out_tdata_q  <= in_tdata[int'(sel)*W +: W];
        out_tid_q    <= sel;
        out_tlast_q  <= (state_q == S_SECOND);
        out_tvalid_q <= 1'b1;
      end else if (out_tready) begin
        out_tvalid_q <= 1'b0;
      end

      if (hs) begin
        if (state_q == S_IDLE) begin
          grant_q <= pick;
          state_q <= S_SECOND;
        end else begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= S_IDLE;
        end
      end
    end
  end

  assign out_tdata  = out_tdata_q;
  assign out_tvalid = out_tvalid_q;
  assign out_tid    = out_tid_q;
  assign out_tlast  = out_tlast_q;
  assign busy       = (state_q == S_SECOND);

endmodule

// File: tb/tb_upsize_pair_arbiter.sv
// ---------------------------------------------------------------------------
// tb_upsize_pair_arbiter
//
// Directed bench for upsize_pair_arbiter (W=40, N=4). Inputs change and
// outputs are sampled on the falling clock edge; each scenario runs from a
// fresh reset.
// ---------------------------------------------------------------------------
module tb_upsize_pair_arbiter;

  localparam int W   = 40;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           aclk;
  logic           aresetn;
  logic [N*W-1:0] in_tdata;
  logic [N-1:0]   in_tvalid;
  logic [N-1:0]   in_tready;
  logic [W-1:0]   out_tdata;
  logic           out_tvalid;
  logic           out_tready;
  logic [IDW-1:0] out_tid;
  logic           out_tlast;
  logic           busy;

  int n_chk;
  int n_fail;

  upsize_pair_arbiter #(.W(W), .N(N), .IDW(IDW)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tid    (out_tid),
    .out_tlast  (out_tlast),
    .busy       (busy)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic set_src(input int s, input logic [W-1:0] d);
    in_tdata[s*W +: W] = d;
  endtask

  task automatic do_reset;
    aresetn    = 1'b0;
    in_tvalid  = '0;
    in_tdata   = '0;
    out_tready = 1'b0;
    step;
    step;
    aresetn = 1'b1;
  endtask

  function automatic logic [W-1:0] bp_data(input int s, input int k);
    return {8'h50 + 8'(s), 24'hC0FFEE, 8'(k)};
  endfunction

  task automatic test_reset;
    aresetn    = 1'b0;
    in_tvalid  = '0;
    in_tdata   = '0;
    out_tready = 1'b0;
    repeat (6) step;
    n_chk++;
    if (out_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_tvalid: got %b expected 0", out_tvalid);
    end
    n_chk++;
    if (out_tdata !== '0) begin
      n_fail++; $display("FAIL reset_out_tdata: got %h expected 0", out_tdata);
    end
    n_chk++;
    if ({out_tid, out_tlast, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_tid_tlast_busy: got %b expected 0000", {out_tid, out_tlast, busy});
    end
    n_chk++;
    if (in_tready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_in_tready: got %b expected 0000", in_tready);
    end
    set_src(2, "RSTOK");
    in_tvalid = 4'b0100;
    aresetn   = 1'b1;
    #1;
    n_chk++;
    if (in_tready !== 4'b0100) begin
      n_fail++; $display("FAIL reset_release_ready: got %b expected 0100", in_tready);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] w [4];
    w[0] = "ABCDE"; w[1] = "FGHIJ"; w[2] = "KLMON"; w[3] = "PQRST";
    do_reset;
    out_tready = 1'b1;
    in_tvalid  = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      set_src(1, w[k]);
      #1;
      n_chk++;
      if (in_tready !== 4'b0010) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 0010", k, in_tready);
      end
      step;
      n_chk++;
      if ({out_tvalid, out_tdata, out_tid, out_tlast} !== {1'b1, w[k], 2'd1, (k % 2 == 1)}) begin
        n_fail++;
        $display("FAIL b2b_beat[%0d]: got v=%b d=%h id=%0d l=%b expected v=1 d=%h id=1 l=%0d",
                 k, out_tvalid, out_tdata, out_tid, out_tlast, w[k], k % 2);
      end
    end
    in_tvalid = '0;
    step;
    n_chk++;
    if (out_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: got %b expected 0", out_tvalid);
    end
  endtask

  task automatic test_pair_lock;
    do_reset;
    out_tready = 1'b1;
    set_src(0, "ABCDE");
    set_src(3, "UVWXY");
    in_tvalid = 4'b1001;
    #1;
    n_chk++;
    if (in_tready !== 4'b0001) begin
      n_fail++; $display("FAIL lock_first_ready: got %b expected 0001", in_tready);
    end
    step;
    n_chk++;
    if ({out_tvalid, out_tdata, out_tid, out_tlast} !== {1'b1, 40'("ABCDE"), 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL lock_beat0: got d=%h id=%0d l=%b expected d=%h id=0 l=0",
                         out_tdata, out_tid, out_tlast, 40'("ABCDE"));
    end
    in_tvalid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++;
      if (in_tready !== 4'b0001) begin
        n_fail++; $display("FAIL lock_gap_ready[%0d]: got %b expected 0001", k, in_tready);
      end
      step;
      n_chk++;
      if ({out_tvalid, busy} !== 2'b01) begin
        n_fail++; $display("FAIL lock_gap_state[%0d]: got valid=%b busy=%b expected valid=0 busy=1",
                           k, out_tvalid, busy);
      end
    end
    set_src(0, "FGHIJ");
    in_tvalid = 4'b1001;
    step;
    n_chk++;
    if ({out_tvalid, out_tdata, out_tid, out_tlast} !== {1'b1, 40'("FGHIJ"), 2'd0, 1'b1}) begin
      n_fail++; $display("FAIL lock_beat1: got d=%h id=%0d l=%b expected d=%h id=0 l=1",
                         out_tdata, out_tid, out_tlast, 40'("FGHIJ"));
    end
    in_tvalid = 4'b1000;
    step;
    n_chk++;
    if ({out_tvalid, out_tdata, out_tid, out_tlast} !== {1'b1, 40'("UVWXY"), 2'd3, 1'b0}) begin
      n_fail++; $display("FAIL lock_src3: got d=%h id=%0d l=%b expected d=%h id=3 l=0",
                         out_tdata, out_tid, out_tlast, 40'("UVWXY"));
    end
    set_src(3, "Z0123");
    step;
    n_chk++;
    if ({out_tvalid, out_tdata, out_tid, out_tlast} !== {1'b1, 40'("Z0123"), 2'd3, 1'b1}) begin
      n_fail++; $display("FAIL lock_src3_second: got d=%h id=%0d l=%b expected d=%h id=3 l=1",
                         out_tdata, out_tid, out_tlast, 40'("Z0123"));
    end
    in_tvalid = '0;
    step;
  endtask

  task automatic test_round_robin;
    logic [IDW-1:0] etid;
    do_reset;
    out_tready = 1'b1;
    for (int s = 0; s < N; s++) set_src(s, bp_data(s, 99));
    in_tvalid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      step;
      etid = IDW'((k / 2) % N);
      n_chk++;
      if ({out_tvalid, out_tid, out_tlast, out_tdata} !== {1'b1, etid, (k % 2 == 1), bp_data(int'(etid), 99)}) begin
        n_fail++; $display("FAIL rr_beat[%0d]: got v=%b id=%0d l=%b expected v=1 id=%0d l=%0d",
                           k, out_tvalid, out_tid, out_tlast, etid, k % 2);
      end
    end
    in_tvalid = '0;
    step;
  endtask

  task automatic test_backpressure;
    int             sent [4];
    int             rcv  [4];
    logic           stall_prev;
    logic [W-1:0]   prev_data;
    logic [IDW-1:0] prev_tid;
    logic           prev_tlast;
    logic [IDW-1:0] last_tid;
    logic [N-1:0]   in_hs;
    logic           done;
    do_reset;
    for (int s = 0; s < 4; s++) begin sent[s] = 0; rcv[s] = 0; end
    stall_prev = 1'b0;
    prev_data  = '0;
    prev_tid   = '0;
    prev_tlast = 1'b0;
    last_tid   = '0;
    done       = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (c < 16)      out_tready = c[0];
      else if (c < 24) out_tready = 1'b0;
      else if (c < 32) out_tready = 1'b1;
      else if (c < 82) out_tready = 1'($urandom_range(0, 1));
      else             out_tready = 1'b1;
      for (int s = 0; s < 3; s++) begin
        if (sent[s] < 6) begin
          in_tvalid[s] = 1'b1;
          set_src(s, bp_data(s, sent[s]));
        end else begin
          in_tvalid[s] = 1'b0;
        end
      end
      in_tvalid[3] = 1'b0;
      #1;
      if (stall_prev) begin
        n_chk++;
        if ({out_tvalid, out_tdata, out_tid, out_tlast} !== {1'b1, prev_data, prev_tid, prev_tlast}) begin
          n_fail++; $display("FAIL bp_stall_stable[c=%0d]: got d=%h id=%0d l=%b expected d=%h id=%0d l=%b",
                             c, out_tdata, out_tid, out_tlast, prev_data, prev_tid, prev_tlast);
        end
      end
      if (out_tvalid && out_tready) begin
        n_chk++;
        if (out_tid >= 3 || rcv[out_tid] >= 6) begin
          n_fail++; $display("FAIL bp_extra_beat[c=%0d]: got id=%0d d=%h expected no further beat",
                             c, out_tid, out_tdata);
        end else if ({out_tdata, out_tlast} !== {bp_data(int'(out_tid), rcv[out_tid]), (rcv[out_tid] % 2 == 1)}) begin
          n_fail++; $display("FAIL bp_scoreboard[c=%0d]: got id=%0d d=%h l=%b expected d=%h l=%0d",
                             c, out_tid, out_tdata, out_tlast,
                             bp_data(int'(out_tid), rcv[out_tid]), rcv[out_tid] % 2);
        end
        if (out_tlast) begin
          n_chk++;
          if (out_tid !== last_tid) begin
            n_fail++; $display("FAIL bp_pair_tid[c=%0d]: got %0d expected %0d", c, out_tid, last_tid);
          end
        end
        last_tid = out_tid;
        rcv[out_tid]++;
      end
      stall_prev = out_tvalid & ~out_tready;
      prev_data  = out_tdata;
      prev_tid   = out_tid;
      prev_tlast = out_tlast;
      in_hs      = in_tvalid & in_tready;
      done       = (rcv[0] == 6) && (rcv[1] == 6) && (rcv[2] == 6);
      step;
      for (int s = 0; s < N; s++) if (in_hs[s]) sent[s]++;
    end
    for (int s = 0; s < 3; s++) begin
      n_chk++;
      if (rcv[s] != 6) begin
        n_fail++; $display("FAIL bp_count_src%0d: got %0d beats expected 6", s, rcv[s]);
      end
    end
    in_tvalid  = '0;
    out_tready = 1'b1;
    step;
  endtask

  task automatic test_async_reset;
    do_reset;
    out_tready = 1'b1;
    set_src(1, "P1AAA");
    in_tvalid = 4'b0010;
    step;
    set_src(1, "P1BBB");
    step;
    set_src(2, "P2AAA");
    in_tvalid = 4'b0100;
    step;
    n_chk++;
    if ({out_tvalid, out_tid, out_tlast, busy} !== {1'b1, 2'd2, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL areset_pre: got v=%b id=%0d l=%b busy=%b expected v=1 id=2 l=0 busy=1",
                         out_tvalid, out_tid, out_tlast, busy);
    end
    in_tvalid = '0;
    #2;
    aresetn = 1'b0;
    #1;
    n_chk++;
    if ({out_tvalid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL areset_immediate: got valid=%b busy=%b expected 0 0", out_tvalid, busy);
    end
    step;
    step;
    set_src(0, "S0NEW");
    set_src(2, "P2BBB");
    set_src(3, "S3XXX");
    in_tvalid = 4'b1101;
    aresetn   = 1'b1;
    #1;
    n_chk++;
    if (in_tready !== 4'b0001) begin
      n_fail++; $display("FAIL areset_after_ready: got %b expected 0001", in_tready);
    end
    step;
    n_chk++;
    if ({out_tvalid, out_tdata, out_tid, out_tlast} !== {1'b1, 40'("S0NEW"), 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL areset_after_beat: got d=%h id=%0d l=%b expected d=%h id=0 l=0",
                         out_tdata, out_tid, out_tlast, 40'("S0NEW"));
    end
    in_tvalid = '0;
    step;
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    aresetn    = 1'b0;
    in_tvalid  = '0;
    in_tdata   = '0;
    out_tready = 1'b0;
    test_reset;
    test_back_to_back;
    test_pair_lock;
    test_round_robin;
    test_backpressure;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/upsize_pair_arbiter.md
Name: upsize_pair_arbiter

Overview:
- Round-robin arbiter that shares one W-bit AXI-Stream input of the 2:1 upsizer between N requesters.
- Grants are held for exactly two accepted beats (one pair), so each 2W upsized word holds data from a single source.
- Output passes through a one-entry registered stage, so out_* signals are flop-driven.
- Sits directly in front of the upsizer; out_tid is forwarded as sideband.

Parameters:
- W, 40, data width of one beat.
- N, 4, number of requesters (N >= 2).
- IDW, $clog2(N), width of out_tid.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- in_tdata  in  N*W  requester data; source i occupies bits [i*W +: W].
- in_tvalid  in  N  per-requester valid.
- in_tready  out  N  per-requester ready.
- out_tdata  out  W  beat to the upsizer.
- out_tvalid  out  1  output valid.
- out_tready  in  1  upsizer ready.
- out_tid  out  IDW  source index of the current output beat.
- out_tlast  out  1  1 = second beat of a pair.
- busy  out  1  1 while a pair is open (state SECOND).

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, rr_ptr = 0, out_tvalid = 0.
  - out_tdata, out_tid, out_tlast = 0; in_tready = 0; busy = 0.
- Output stage:
  - stage_ok = ~out_tvalid | out_tready.
  - A beat accepted from a source loads out_tdata, out_tid and out_tlast on the same edge and sets out_tvalid.
  - out_tvalid clears when out_tready is high and no new beat loads.
  - Output is stable while out_tvalid & ~out_tready.
  - Full throughput: one beat per cycle when out_tready = 1. Latency from input handshake to out_tvalid is 1 cycle.
- State IDLE:
  - pick = first i with in_tvalid[i] = 1, searching rr_ptr, rr_ptr+1, ... mod N.
  - in_tready[pick] = stage_ok; every other in_tready = 0.
  - On handshake: load the beat with out_tlast = 0, grant = pick, go to SECOND.
  - No handshake (no valid, or stage full): stay in IDLE and re-pick next cycle. A late lower-index request may win; this is legal.
- State SECOND:
  - in_tready[grant] = stage_ok; every other in_tready = 0. Other requesters are ignored even when valid.
  - Gaps in in_tvalid[grant] are allowed; the lock holds indefinitely until the second beat arrives.
  - On handshake: load the beat with out_tlast = 1, rr_ptr = (grant+1) mod N, go to IDLE.
  - The next pair's first beat may be accepted on the cycle after the second beat (no bubble).
- Fairness: with all N requesters continuously valid, pairs are granted 0,1,...,N-1,0,...
- Simultaneous events: stage drain and stage load in the same cycle are allowed and result in a load. in_tready never depends on out_tready other than through stage_ok.
- Reset mid-pair:
  - A half-pair already emitted downstream is not recovered; the upsizer must be reset together with this block.
  - After reset the block is in IDLE with rr_ptr = 0.
- in_tready is combinational from state, in_tvalid and stage_ok. No other combinational input-to-output paths exist.

Test Plan:
- Reset: hold aresetn = 0 for 6 cycles -> all outputs 0. Release with only in_tvalid[2] = 1 -> in_tready[2] = 1 on the first cycle.
- Back-to-back single source: src1 sends "ABCDE","FGHIJ","KLMON","PQRST" with out_tready = 1.
  - Output beats appear one cycle later with out_tid = 1.
  - out_tlast = 0,1,0,1; no idle cycles.
- Pair lock against contention: src0 sends "ABCDE", then drops valid for 3 cycles while src3 holds "UVWXY" valid.
  - src3 is not granted until src0 supplies "FGHIJ".
  - Output order: ABCDE(0), FGHIJ(0), then UVWXY(3).
- Round-robin: all 4 sources continuously valid, out_tready = 1 -> out_tid sequence 0,0,1,1,2,2,3,3,0,0 and out_tlast alternates 0,1.
- Backpressure: out_tready pattern toggling every cycle, then 8 low / 8 high, then random for 50 cycles, with 3 sources sending 6 beats each.
  - No beat lost or duplicated; output stable while stalled.
  - Every out_tlast=1 beat has the same out_tid as the preceding beat.
  - Scoreboard per source matches input order.
- Async reset mid-pair: assert aresetn = 0 between the first and second beat of a src2 pair -> immediate out_tvalid = 0 and busy = 0. After release, the next grant starts from src0.
